// File: rtl/core_pkg.sv
// Shared core types: datapath widths, the canonical NOP and the fetch entry
// that travels from the PC stage through the fetch FIFO to decode.
package core_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO. Flush beats push/pop; push and pop may coincide
// when full, which keeps occupancy constant.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every always_ff
    // sees the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the count qualifies every read,
    // so resetting it would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, fault check against the memory map, push and
// redirect control into the fetch FIFO, and the delivered-instruction counter.
module ifetch
    import core_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                DEPTH      = 2,
    parameter int                IMEM_WORDS = 4096
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  iaddr,
    input  logic [INSTR_W-1:0] idata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               out_fault,
    output logic [31:0]        fetch_count
);

    logic [ADDR_W-1:0] pc;
    logic              fault;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;

    assign iaddr = pc;
    assign fault = (pc[1:0] != 2'b00) || ({2'b00, pc[ADDR_W-1:2]} >= ADDR_W'(IMEM_WORDS));
    assign pop   = out_valid && out_ready;
    assign push  = !redirect_valid && (!full || pop);

    // NOTE: every field gets a value on every path through the block, so no
    // latch can be inferred.
    always_comb begin
        wr_entry.pc    = pc;
        wr_entry.fault = fault;
        wr_entry.instr = fault ? NOP_INSTR : idata;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Head fields read as zero whenever nothing is buffered.
    assign out_valid = !empty;
    assign out_pc    = empty ? '0 : head.pc;
    assign out_instr = empty ? '0 : head.instr;
    assign out_fault = !empty && head.fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            if (pop) fetch_count <= fetch_count + 1'b1;
            if (redirect_valid)
                pc <= redirect_pc;
            else if (push)
                pc <= pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios with literal expectations, then random
// ready/redirect/reset traffic compared every cycle against a queue model.
module tb_ifetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          DEPTH      = 2;
    localparam int          IMEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    logic [31:0] mem [IMEM_WORDS];
    assign idata = mem[iaddr[13:2]];

    ifetch #(
        .RESET_PC   (RESET_PC),
        .DEPTH      (DEPTH),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .iaddr          (iaddr),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .fetch_count    (fetch_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffered instructions as a queue, plus PC and count.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_count = 0;
    bit          cmp_en  = 0;

    task automatic model_step();
        bit   was_full;
        bit   hs;
        ent_t e;
        if (reset) begin
            q.delete();
            m_pc    = RESET_PC;
            m_count = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            hs       = (q.size() != 0) && out_ready;
            if (hs) begin
                m_count = m_count + 1;
                void'(q.pop_front());
            end
            if (redirect_valid) begin
                q.delete();
                m_pc = redirect_pc;
            end else if (!was_full || hs) begin
                e.pc    = m_pc;
                e.fault = (m_pc[1:0] != 2'b00) || ((m_pc >> 2) >= IMEM_WORDS);
                e.instr = e.fault ? 32'h0000_0013 : mem[m_pc[13:2]];
                q.push_back(e);
                m_pc = m_pc + 4;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("iaddr", iaddr, m_pc);
            check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            check("out_pc", out_pc, (q.size() != 0) ? q[0].pc : 32'h0);
            check("out_instr", out_instr, (q.size() != 0) ? q[0].instr : 32'h0);
            check("out_fault", {31'b0, out_fault}, {31'b0, (q.size() != 0) && q[0].fault});
            check("fetch_count", fetch_count, m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    logic [31:0] tgt;
    int          r;

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;

        @(negedge clk);
        cmp_en = 1;
        tick();

        // Reset state and first three fetches at full throughput.
        reset = 1'b0;
        check("rst_iaddr", iaddr, RESET_PC);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_count", fetch_count, 32'd0);
        tick();
        check("seq0_valid", {31'b0, out_valid}, 32'd1);
        check("seq0_pc", out_pc, 32'h0);
        check("seq0_instr", out_instr, 32'h11);
        tick();
        check("seq1_pc", out_pc, 32'h4);
        check("seq1_instr", out_instr, 32'h22);
        tick();
        check("seq2_pc", out_pc, 32'h8);
        check("seq2_instr", out_instr, 32'h33);
        tick();
        check("seq_count", fetch_count, 32'd3);

        // Backpressure fills the FIFO and freezes the PC.
        out_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        check("stall_iaddr", iaddr, 32'h8);
        check("stall_head", out_pc, 32'h0);
        check("stall_count", fetch_count, 32'd0);
        out_ready = 1'b1;
        tick();
        check("resume0", out_pc, 32'h4);
        tick();
        check("resume1", out_pc, 32'h8);
        tick();
        check("resume2", out_pc, 32'hC);
        check("resume_count", fetch_count, 32'd3);

        // Redirect while full with a handshake in the same cycle.
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        redirect_to(32'h40);
        check("redir_count", fetch_count, 32'd4);
        check("redir_valid", {31'b0, out_valid}, 32'd0);
        check("redir_iaddr", iaddr, 32'h40);
        tick();
        check("redir_pc", out_pc, 32'h40);
        check("redir_instr", out_instr, mem[16]);

        // Misaligned and out-of-range targets, plus the last valid word.
        redirect_to(32'h42);
        tick();
        check("mis_pc", out_pc, 32'h42);
        check("mis_fault", {31'b0, out_fault}, 32'd1);
        check("mis_instr", out_instr, 32'h0000_0013);
        redirect_to(32'h4000);
        tick();
        check("oor_fault", {31'b0, out_fault}, 32'd1);
        redirect_to(32'h3FFC);
        tick();
        check("last_fault", {31'b0, out_fault}, 32'd0);
        check("last_instr", out_instr, mem[4095]);
        tick();
        check("edge_pc", out_pc, 32'h4000);
        check("edge_fault", {31'b0, out_fault}, 32'd1);

        // Reset wins over a same-cycle redirect and handshake.
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        check("rr_iaddr", iaddr, RESET_PC);
        check("rr_valid", {31'b0, out_valid}, 32'd0);
        check("rr_count", fetch_count, 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = 1'b0;
            reset          = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 6) begin
                case ($urandom_range(0, 4))
                    0: tgt = {18'b0, 12'($urandom_range(0, 4095)), 2'b00};
                    1: tgt = 32'h0000_3FF8;
                    2: tgt = 32'hFFFF_FFF8;
                    3: tgt = $urandom;
                    default: tgt = {18'b0, 12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3))};
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
            end else if (r == 99) begin
                reset = 1'b1;
            end
            tick();
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
